// File: rtl/mult_disp_pkg.sv
// Shared constants for the multiplier display path: segment patterns, BCD width helper, scan states.
package mult_disp_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Number of BCD digits needed for a 2n-bit binary product.
    function automatic int bcd_digits(input int n);
        return ((2 * n) / 3) + 1;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// BCD nibble to active-low seven-segment pattern; illegal nibbles show "E".
// Latency: combinational. Backpressure: none.
// Blank input overrides the decode and turns every segment off.
module bcd_to_seg
    import mult_disp_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (nib)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Captures the BCD product on the rising edge of finish and scans it onto a common-anode display.
// Latency: capture registers on edge E, seg/an show the new value from edge E+1.
// Backpressure: none; finish is level-sampled and only its rising edge captures.
module bcd_display_driver
    import mult_disp_pkg::*;
#(
    parameter int N           = 5,
    parameter int DIGITS      = bcd_digits(N),
    parameter int REFRESH_DIV = 4,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS*4-1:0]   bcd,
    input  logic                  finish,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  valid,
    output logic                  err
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    state_t              state_q;
    state_t              state_nxt;
    logic                fin_q;
    logic                capture;
    logic                cap_err;
    logic [DIGITS*4-1:0] held_q;
    logic [PW-1:0]       pre_q;
    logic [IW-1:0]       idx_q;
    logic [DIGITS-1:0]   blank_mask;
    logic                nz_seen;
    logic [3:0]          cur_nib;
    logic                cur_blank;
    logic [DIGITS-1:0]   cur_an;
    logic [6:0]          cur_seg;

    assign capture = finish & ~fin_q;

    always_comb begin
        cap_err = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[k*4 +: 4] > 4'd9) cap_err = 1'b1;
        end
    end

    // Walk from the top digit down; a digit blanks only while nothing above it is non-zero.
    always_comb begin
        nz_seen    = 1'b0;
        blank_mask = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (held_q[k*4 +: 4] != 4'd0) nz_seen = 1'b1;
            blank_mask[k] = BLANK_LZ && !nz_seen && (k != 0);
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        cur_an    = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib   = held_q[k*4 +: 4];
                cur_blank = blank_mask[k];
                cur_an[k] = 1'b0;
            end
        end
    end

    bcd_to_seg u_bcd_to_seg (
        .nib   (cur_nib),
        .blank (cur_blank),
        .seg   (cur_seg)
    );

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (capture) state_nxt = SCAN;
            SCAN:    state_nxt = SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            fin_q   <= 1'b0;
            held_q  <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
            seg     <= SEG_BLANK;
            an      <= '1;
        end else begin
            state_q <= state_nxt;
            fin_q   <= finish;
            if (capture) begin
                held_q <= bcd;
                valid  <= 1'b1;
                err    <= cap_err;
            end
            // A recapture while scanning leaves the counters running.
            if (state_q == SCAN) begin
                if (pre_q == PRE_LAST) begin
                    pre_q <= '0;
                    idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    pre_q <= pre_q + 1'b1;
                end
                seg <= cur_seg;
                an  <= cur_an;
            end
        end
    end

endmodule
